// File: rtl/inverter_defs.sv
// Shared definitions for the pipelined inverter: mode encodings and default sizes.
package inverter_defs;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 3;
  localparam int DEF_COUNT_W = 16;

  // Per-word operation carried alongside the data word.
  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_INV     = 2'd1,
    MODE_MASK    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

endpackage

// File: rtl/inverter_stage.sv
// One pipeline slot: a WIDTH-bit data register plus its valid bit, loaded on i_load.
module inverter_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;

  // Capture the upstream word and its valid bit whenever this slot may advance.
  // NOTE: state registers use non-blocking assignments so every stage samples
  // its upstream neighbour's pre-edge value, regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_data  <= i_data;
      r_valid <= i_valid;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/inverter_pipe.sv
// Pipelined pass / invert / masked-invert datapath with valid-ready handshake,
// bubble-collapsing backpressure, a saturating output-transfer counter and a
// sticky illegal-mode flag.
module inverter_pipe
  import inverter_defs::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   mask,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   y,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] xfer_count,
  output logic               mode_err
);

  logic [WIDTH-1:0]   w_func;
  logic               w_in_xfer;
  logic               w_out_xfer;
  logic [COUNT_W-1:0] r_xfer_count;
  logic               r_mode_err;

  // Apply the word's operation once, on the way into stage 1.
  // NOTE: the default assignment first guarantees every path drives w_func,
  // so no latch is inferred for unlisted or illegal modes.
  always_comb begin
    w_func = a;
    case (mode_e'(mode))
      MODE_INV:  w_func = ~a;
      MODE_MASK: w_func = a ^ mask;
      default:   w_func = a;
    endcase
  end

  // Stage chain: each stage advances when it is empty or its downstream
  // neighbour advances, so bubbles fill even while the output is stalled.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             w_ready;
    logic             w_valid;
    logic             w_up_valid;
    logic             w_down_ready;
    logic [WIDTH-1:0] w_data;
    logic [WIDTH-1:0] w_up_data;

    if (i == 0) begin : g_first
      assign w_up_data  = w_func;
      assign w_up_valid = in_valid;
    end else begin : g_follow
      assign w_up_data  = g_stage[i-1].w_data;
      assign w_up_valid = g_stage[i-1].w_valid;
    end

    if (i == DEPTH - 1) begin : g_last
      assign w_down_ready = out_ready;
    end else begin : g_inner
      assign w_down_ready = g_stage[i+1].w_ready;
    end

    assign w_ready = ~w_valid | w_down_ready;

    inverter_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_ready),
      .i_data  (w_up_data),
      .i_valid (w_up_valid),
      .o_data  (w_data),
      .o_valid (w_valid)
    );
  end

  assign in_ready  = g_stage[0].w_ready;
  assign out_valid = g_stage[DEPTH-1].w_valid;
  assign y         = g_stage[DEPTH-1].w_data;

  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Count completed output transfers, holding at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xfer_count <= '0;
    end else if (w_out_xfer && (r_xfer_count != {COUNT_W{1'b1}})) begin
      r_xfer_count <= r_xfer_count + COUNT_W'(1);
    end
  end

  // Latch any accepted illegal-mode word; only reset clears the flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_err <= 1'b0;
    end else if (w_in_xfer && (mode_e'(mode) == MODE_ILLEGAL)) begin
      r_mode_err <= 1'b1;
    end
  end

  assign xfer_count = r_xfer_count;
  assign mode_err   = r_mode_err;

endmodule

// File: tb/tb_inverter_pipe.sv
// Directed bench for inverter_pipe: table-driven streaming vectors plus
// hand-written sequences for latency, backpressure, illegal mode, reset and
// counter saturation (the latter on a separate COUNT_W=4 instance).
module tb_inverter_pipe;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int NV    = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [1:0]       mode;
  logic [WIDTH-1:0] mask;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      xfer_count;
  logic             mode_err;

  logic             s_rst;
  logic [WIDTH-1:0] s_a;
  logic             s_in_valid;
  logic             s_in_ready;
  logic [WIDTH-1:0] s_y;
  logic             s_out_valid;
  logic             s_out_ready;
  logic [3:0]       s_xfer_count;
  logic             s_mode_err;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [7:0] a;
    logic [1:0] mode;
    logic [7:0] mask;
    logic [7:0] exp_y;
  } vec_t;

  vec_t vecs [NV];

  inverter_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNT_W(16)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .mode       (mode),
    .mask       (mask),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .y          (y),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .xfer_count (xfer_count),
    .mode_err   (mode_err)
  );

  inverter_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .COUNT_W(4)) u_sat (
    .clk        (clk),
    .rst        (s_rst),
    .a          (s_a),
    .mode       (2'd0),
    .mask       (8'h00),
    .in_valid   (s_in_valid),
    .in_ready   (s_in_ready),
    .y          (s_y),
    .out_valid  (s_out_valid),
    .out_ready  (s_out_ready),
    .xfer_count (s_xfer_count),
    .mode_err   (s_mode_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_xfer_count", 32'(xfer_count), 0);
    check("rst_mode_err", 32'(mode_err), 0);
    check("rst_y", 32'(y), 0);
  endtask

  initial begin
    int acc;
    int rcv;
    int n_sat;
    logic [7:0] w3_a   [5];
    logic [7:0] w3_exp [5];

    n_checks = 0;
    n_fail   = 0;

    vecs[0] = '{8'h00, 2'd0, 8'h0F, 8'h00};
    vecs[1] = '{8'hFF, 2'd1, 8'h0F, 8'h00};
    vecs[2] = '{8'h3C, 2'd2, 8'h0F, 8'h33};
    vecs[3] = '{8'hA5, 2'd0, 8'hFF, 8'hA5};
    vecs[4] = '{8'hA5, 2'd2, 8'hFF, 8'h5A};
    vecs[5] = '{8'h81, 2'd2, 8'h00, 8'h81};
    vecs[6] = '{8'h7E, 2'd1, 8'h00, 8'h81};
    vecs[7] = '{8'hC3, 2'd2, 8'h3C, 8'hFF};

    w3_a   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    w3_exp = '{8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA};

    a = '0; mode = 2'd0; mask = '0; in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    s_rst = 1'b1; s_a = 8'h5A; s_in_valid = 1'b0; s_out_ready = 1'b0;

    // Reset state.
    do_reset();

    // Single beat A5 inverted, latency DEPTH edges counting the capture edge.
    a = 8'hA5; mode = 2'd1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("t1_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      #1;
      check("t1_out_valid", 32'(out_valid), (k == DEPTH) ? 1 : 0);
      if (k == DEPTH) begin
        check("t1_y", 32'(y), 'h5A);
        check("t1_count_pre", 32'(xfer_count), 0);
      end
      tick();
    end
    #1;
    check("t1_count", 32'(xfer_count), 1);
    check("t1_drained", 32'(out_valid), 0);

    // Back-to-back table stream with out_ready held high.
    for (int c = 0; c <= NV + DEPTH; c++) begin
      if (c < NV) begin
        a = vecs[c].a; mode = vecs[c].mode; mask = vecs[c].mask; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c < NV) check("t2_in_ready", 32'(in_ready), 1);
      check("t2_out_valid", 32'(out_valid), (c >= DEPTH && c < DEPTH + NV) ? 1 : 0);
      if (c >= DEPTH && c < DEPTH + NV) check("t2_y", 32'(y), 32'(vecs[c-DEPTH].exp_y));
      tick();
    end
    #1;
    check("t2_count", 32'(xfer_count), 1 + NV);

    // Backpressure: fill with out_ready low, then drain.
    acc = 0; rcv = 0; out_ready = 1'b0; mode = 2'd1; mask = 8'h00;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; a = w3_a[acc];
      #1;
      check("t3_fill_in_ready", 32'(in_ready), (c < 3) ? 1 : 0);
      if (c >= 3) begin
        check("t3_stall_valid", 32'(out_valid), 1);
        check("t3_stall_y", 32'(y), 32'(w3_exp[0]));
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 15; c++) begin
      if (acc < 5) begin
        in_valid = 1'b1; a = w3_a[acc];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (c == 0) check("t3_full_accept", 32'(in_ready), 1);
      if (out_valid && out_ready) begin
        if (rcv < 5) check("t3_drain_y", 32'(y), 32'(w3_exp[rcv]));
        rcv++;
      end
      if (in_valid && in_ready) acc++;
      tick();
    end
    check("t3_accepted", 32'(acc), 5);
    check("t3_received", 32'(rcv), 5);

    // Illegal mode passes data through and sets the sticky flag.
    a = 8'h12; mode = 2'd3; in_valid = 1'b1;
    #1;
    check("t4_err_before", 32'(mode_err), 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("t4_err_set", 32'(mode_err), 1);
    tick();
    tick();
    #1;
    check("t4_out_valid", 32'(out_valid), 1);
    check("t4_y", 32'(y), 'h12);
    tick();
    for (int k = 0; k < 10; k++) begin
      a = 8'(k); mode = 2'd0; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    for (int k = 0; k < DEPTH + 2; k++) tick();
    #1;
    check("t4_err_sticky", 32'(mode_err), 1);
    check("t4_count", 32'(xfer_count), 25);

    // Reset with two words in flight.
    a = 8'h01; mode = 2'd1; in_valid = 1'b1;
    tick();
    a = 8'h02;
    tick();
    in_valid = 1'b0;
    #1;
    check("t5_inflight_no_out", 32'(out_valid), 0);
    do_reset();
    for (int k = 0; k < DEPTH + 2; k++) begin
      #1;
      check("t5_no_stale", 32'(out_valid), 0);
      tick();
    end

    // Saturating counter on the COUNT_W=4 instance.
    s_rst = 1'b0; s_in_valid = 1'b1; s_out_ready = 1'b1;
    n_sat = 0;
    for (int c = 0; c < 31; c++) begin
      #1;
      check("t6_in_ready", 32'(s_in_ready), 1);
      check("t6_count", 32'(s_xfer_count), (n_sat < 15) ? n_sat : 15);
      if (s_out_valid && s_out_ready) n_sat++;
      tick();
    end
    s_in_valid = 1'b0;
    #1;
    check("t6_enough_xfers", 32'(n_sat >= 20), 1);
    check("t6_saturated", 32'(s_xfer_count), 15);
    check("t6_y", 32'(s_y), 'h5A);
    check("t6_no_err", 32'(s_mode_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
